lives_hud_manager: RTL and testbench

//  Parametrised successor to the single-mode life tracker. Holds the player's life count

---
 rtl/lives_hud_manager.sv | 200 ++++++++++++++++++++
 tb/tb_lives_hud_manager.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lives_hud_manager.sv
// Player life tracker with bonus lives and post-hit invulnerability, plus a
// row-of-icons HUD renderer that plots one pixel per cycle on the VGA plot bus.
module lives_hud_manager #(
    parameter int          MAX_LIVES     = 5,
    parameter int          START_LIVES   = 3,
    parameter int          ICON_W        = 4,
    parameter int          ICON_H        = 4,
    parameter int          X0            = 2,
    parameter int          Y0            = 2,
    parameter int          SPACING       = 6,
    parameter logic [2:0]  LIVE_COLOUR   = 3'b100,
    parameter logic [2:0]  DEAD_COLOUR   = 3'b000,
    parameter int          INVULN_CYCLES = 8,
    localparam int         LW            = $clog2(MAX_LIVES + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          lose_a_life,
    input  logic          gain_a_life,
    output logic          idle,
    output logic          game_over,
    output logic [LW-1:0] lives,
    output logic [7:0]    x_out,
    output logic [6:0]    y_out,
    output logic [2:0]    colour_out,
    output logic          write_out
);

    localparam int SW  = (MAX_LIVES > 1) ? $clog2(MAX_LIVES) : 1;
    localparam int PXW = (ICON_W > 1) ? $clog2(ICON_W) : 1;
    localparam int PYW = (ICON_H > 1) ? $clog2(ICON_H) : 1;
    localparam int IW  = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // Life bookkeeping
    // ------------------------------------------------------------------
    logic [LW-1:0] lives_reg, lives_next;
    logic          game_over_reg, game_over_next;
    logic [IW-1:0] invuln_reg, invuln_next;
    logic          pending_reg, pending_next;
    logic          life_changed;

    logic [1:0]    state_reg;
    logic          draw_start;

    always_comb begin
        lives_next     = lives_reg;
        game_over_next = game_over_reg;
        invuln_next    = (invuln_reg != '0) ? invuln_reg - IW'(1) : invuln_reg;
        life_changed   = 1'b0;
        if (!game_over_reg) begin
            if (lose_a_life && !gain_a_life) begin
                if (invuln_reg == '0 && lives_reg != '0) begin
                    lives_next   = lives_reg - LW'(1);
                    invuln_next  = IW'(INVULN_CYCLES);
                    life_changed = 1'b1;
                    if (lives_reg == LW'(1)) begin
                        game_over_next = 1'b1;
                    end
                end
            end else if (gain_a_life && !lose_a_life) begin
                if (lives_reg != LW'(MAX_LIVES)) begin
                    lives_next   = lives_reg + LW'(1);
                    life_changed = 1'b1;
                end
            end
        end
    end

    assign draw_start = (state_reg == S_IDLE) && (enable || pending_reg);

    // A change landing on the same edge a frame starts must survive the clear,
    // otherwise the frame just begun would show the stale count forever.
    always_comb begin
        pending_next = pending_reg;
        if (life_changed) begin
            pending_next = 1'b1;
        end else if (draw_start) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lives_reg     <= LW'(START_LIVES);
            game_over_reg <= 1'b0;
            invuln_reg    <= '0;
            pending_reg   <= 1'b0;
        end else begin
            lives_reg     <= lives_next;
            game_over_reg <= game_over_next;
            invuln_reg    <= invuln_next;
            pending_reg   <= pending_next;
        end
    end

    // ------------------------------------------------------------------
    // Icon renderer
    // ------------------------------------------------------------------
    logic [SW-1:0]  slot_reg;
    logic [PYW-1:0] py_reg;
    logic [PXW-1:0] px_reg;
    logic           last_reg;
    logic [LW-1:0]  snap_reg;
    logic [7:0]     x_reg;
    logic [6:0]     y_reg;
    logic [2:0]     colour_reg;
    logic           write_reg;

    logic [7:0]     x_calc;
    logic [6:0]     y_calc;
    logic [2:0]     colour_calc;
    logic           px_end, py_end, slot_end, at_last;

    assign x_calc      = 8'(X0 + SPACING * int'(slot_reg) + int'(px_reg));
    assign y_calc      = 7'(Y0 + int'(py_reg));
    assign colour_calc = (int'(slot_reg) < int'(snap_reg)) ? LIVE_COLOUR : DEAD_COLOUR;

    assign px_end   = (int'(px_reg) == ICON_W - 1);
    assign py_end   = (int'(py_reg) == ICON_H - 1);
    assign slot_end = (int'(slot_reg) == MAX_LIVES - 1);
    assign at_last  = px_end && py_end && slot_end;

    // last_reg marks that the final pixel is on the bus; the following DRAW
    // cycle drops write_out so DONE is a clean non-writing cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= S_IDLE;
            slot_reg   <= '0;
            py_reg     <= '0;
            px_reg     <= '0;
            last_reg   <= 1'b0;
            snap_reg   <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            write_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    write_reg <= 1'b0;
                    if (draw_start) begin
                        state_reg <= S_DRAW;
                        snap_reg  <= lives_reg;
                        slot_reg  <= '0;
                        py_reg    <= '0;
                        px_reg    <= '0;
                        last_reg  <= 1'b0;
                    end
                end
                S_DRAW: begin
                    if (last_reg) begin
                        write_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        write_reg  <= 1'b1;
                        x_reg      <= x_calc;
                        y_reg      <= y_calc;
                        colour_reg <= colour_calc;
                        last_reg   <= at_last;
                        if (px_end) begin
                            px_reg <= '0;
                            if (py_end) begin
                                py_reg   <= '0;
                                slot_reg <= slot_reg + SW'(1);
                            end else begin
                                py_reg <= py_reg + PYW'(1);
                            end
                        end else begin
                            px_reg <= px_reg + PXW'(1);
                        end
                    end
                end
                S_DONE: begin
                    write_reg <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    write_reg <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign idle       = (state_reg == S_IDLE);
    assign game_over  = game_over_reg;
    assign lives      = lives_reg;
    assign x_out      = x_reg;
    assign y_out      = y_reg;
    assign colour_out = colour_reg;
    assign write_out  = write_reg;

endmodule

// File: tb/tb_lives_hud_manager.sv
// Directed bench for lives_hud_manager: life rules, redraw triggering and pixel stream.
module tb_lives_hud_manager;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       lose_a_life = 1'b0;
    logic       gain_a_life = 1'b0;
    logic       idle;
    logic       game_over;
    logic [2:0] lives;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       write_out;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int qx[$];
    int qy[$];
    int qc[$];

    always #5 clk = ~clk;

    lives_hud_manager dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .lose_a_life(lose_a_life),
        .gain_a_life(gain_a_life),
        .idle       (idle),
        .game_over  (game_over),
        .lives      (lives),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .write_out  (write_out)
    );

    // Record every plotted pixel shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (write_out === 1'b1) begin
            qx.push_back(int'(x_out));
            qy.push_back(int'(y_out));
            qc.push_back(int'(colour_out));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
            $display("ok   %s: got %0d", tag, got);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        qx.delete();
        qy.delete();
        qc.delete();
    endtask

    function automatic int live_in(input int s, input int n);
        int c = 0;
        for (int i = s; i < s + n; i++) begin
            if (i < qc.size() && qc[i] == 4) c++;
        end
        return c;
    endfunction

    task automatic pulse_lose();
        lose_a_life = 1'b1;
        @(negedge clk);
        lose_a_life = 1'b0;
    endtask

    task automatic pulse_gain();
        gain_a_life = 1'b1;
        @(negedge clk);
        gain_a_life = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Waits for idle to stay high for 4 samples; a blown budget is a failure.
    task automatic wait_idle(input string tag);
        int run = 0;
        int n = 0;
        while (run < 4 && n < 1000) begin
            @(negedge clk);
            n++;
            if (idle) run++;
            else run = 0;
        end
        if (run < 4) check({tag, " idle timeout"}, 0, 1);
    endtask

    initial begin
        int wcnt;
        int ilow;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst lives", int'(lives), 3);
        check("rst game_over", int'(game_over), 0);
        check("rst idle", int'(idle), 1);
        check("rst write", int'(write_out), 0);
        check("rst x", int'(x_out), 0);
        check("rst y", int'(y_out), 0);
        check("rst colour", int'(colour_out), 0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: enable-triggered full redraw
        clear_q();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("t1 idle after start", int'(idle), 0);
        check("t1 no write yet", int'(write_out), 0);
        wcnt = 0;
        ilow = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (write_out) wcnt++;
            if (!idle) ilow++;
        end
        check("t1 write cycles", wcnt, 80);
        check("t1 idle low cycles", ilow, 80);
        @(negedge clk);
        check("t1 done write", int'(write_out), 0);
        check("t1 done idle", int'(idle), 0);
        @(negedge clk);
        check("t1 back idle", int'(idle), 1);
        check("t1 pixel count", qx.size(), 80);
        check("t1 p0 x", qx[0], 2);
        check("t1 p0 y", qy[0], 2);
        check("t1 p0 c", qc[0], 4);
        check("t1 p48 x", qx[48], 20);
        check("t1 p48 y", qy[48], 2);
        check("t1 p48 c", qc[48], 0);
        check("t1 p79 x", qx[79], 29);
        check("t1 p79 y", qy[79], 5);
        check("t1 p79 c", qc[79], 0);
        check("t1 live pixels", live_in(0, 80), 48);

        // 2: run down to game over
        clear_q();
        pulse_lose();
        check("t2 lives 2", int'(lives), 2);
        repeat (9) @(negedge clk);
        pulse_lose();
        check("t2 lives 1", int'(lives), 1);
        repeat (9) @(negedge clk);
        pulse_lose();
        check("t2 lives 0", int'(lives), 0);
        check("t2 game_over", int'(game_over), 1);
        wait_idle("t2");
        check("t2 pixel count", qx.size(), 160);
        check("t2 frame1 live", live_in(0, 80), 32);
        check("t2 frame2 live", live_in(80, 80), 0);
        pulse_gain();
        check("t2 gain ignored", int'(lives), 0);
        check("t2 still over", int'(game_over), 1);
        repeat (3) @(negedge clk);
        check("t2 no redraw", int'(idle), 1);

        // 3: invulnerability window
        do_reset();
        check("t3 reset lives", int'(lives), 3);
        check("t3 reset game_over", int'(game_over), 0);
        pulse_lose();
        check("t3 first hit", int'(lives), 2);
        repeat (2) @(negedge clk);
        pulse_lose();
        check("t3 hit at t+3", int'(lives), 2);
        repeat (5) @(negedge clk);
        pulse_lose();
        check("t3 hit at t+9", int'(lives), 1);
        wait_idle("t3");

        // 4: bonus lives saturate
        do_reset();
        clear_q();
        pulse_gain();
        check("t4 lives 4", int'(lives), 4);
        wait_idle("t4a");
        pulse_gain();
        check("t4 lives 5", int'(lives), 5);
        wait_idle("t4b");
        pulse_gain();
        check("t4 lives ceiling", int'(lives), 5);
        wait_idle("t4c");
        check("t4 pixel count", qx.size(), 160);
        check("t4 frame1 live", live_in(0, 80), 64);
        check("t4 frame2 live", live_in(80, 80), 80);

        // 5: simultaneous lose and gain
        clear_q();
        lose_a_life = 1'b1;
        gain_a_life = 1'b1;
        @(negedge clk);
        gain_a_life = 1'b0;
        check("t5 net unchanged", int'(lives), 5);
        @(negedge clk);
        lose_a_life = 1'b0;
        check("t5 next lose", int'(lives), 4);
        check("t5 no redraw from tie", int'(idle), 1);
        wait_idle("t5");
        check("t5 pixel count", qx.size(), 80);
        check("t5 frame live", live_in(0, 80), 64);

        // 6: hit during redraw, then reset mid-frame
        clear_q();
        pulse_lose();
        check("t6 lives 3", int'(lives), 3);
        repeat (20) @(negedge clk);
        pulse_lose();
        check("t6 lives 2", int'(lives), 2);
        wait_idle("t6");
        check("t6 pixel count", qx.size(), 160);
        check("t6 frame1 live", live_in(0, 80), 48);
        check("t6 frame2 live", live_in(80, 80), 32);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("t6 mid frame write", int'(write_out), 1);
        resetn = 1'b0;
        #1;
        check("t6 abort write", int'(write_out), 0);
        check("t6 abort lives", int'(lives), 3);
        check("t6 abort idle", int'(idle), 1);
        check("t6 abort x", int'(x_out), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
